// File: rtl/cfu_dot_sequencer_pkg.sv
// ============================================================================
// Module : cfu_dot_sequencer_pkg
// Brief  : CFU function codes, expected response tags, codebook modes and states
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cfu_dot_sequencer_pkg;

    localparam logic [6:0] c_f7_push  = 7'h10;
    localparam logic [6:0] c_f7_cb2   = 7'h20;
    localparam logic [6:0] c_f7_cb4   = 7'h28;
    localparam logic [6:0] c_f7_cb16  = 7'h38;
    localparam logic [6:0] c_f7_mac   = 7'h40;
    localparam logic [6:0] c_f7_rst   = 7'h48;
    localparam logic [6:0] c_f7_read  = 7'h50;

    localparam logic [31:0] c_tag_rst   = 32'h0000_0000;
    localparam logic [31:0] c_tag_cb2   = 32'hAABB_2202;
    localparam logic [31:0] c_tag_cb4   = 32'hAABB_4404;
    localparam logic [31:0] c_tag_cb16a = 32'hAABB_16A0;
    localparam logic [31:0] c_tag_cb16b = 32'hAABB_16B1;
    localparam logic [31:0] c_tag_push  = 32'hDEAD_0000;
    localparam logic [31:0] c_tag_mac   = 32'hABCD_0001;

    typedef enum logic [1:0] {
        CB_MODE_2   = 2'd0,
        CB_MODE_4   = 2'd1,
        CB_MODE_16  = 2'd2,
        CB_MODE_BAD = 2'd3
    } cb_mode_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RST    = 4'd1,
        S_CB     = 4'd2,
        S_CB16B  = 4'd3,
        S_WFETCH = 4'd4,
        S_PUSH   = 4'd5,
        S_AFETCH = 4'd6,
        S_MAC    = 4'd7,
        S_READ   = 4'd8,
        S_OUT    = 4'd9
    } seq_state_e;

    function automatic logic [9:0] cfu_fid(input logic [6:0] funct7);
        return {funct7, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfu_dot_sequencer_if.sv
// ============================================================================
// Module : cfu_dot_sequencer_if
// Brief  : CFU cmd/rsp bus; master = command initiator, slave = CFU
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cfu_dot_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

`default_nettype wire

// File: rtl/cfu_dot_sequencer_cmd_issuer.sv
// ============================================================================
// Module : cfu_dot_sequencer_cmd_issuer
// Brief  : One-outstanding CFU command port: start -> cmd handshake -> rsp -> done
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cfu_dot_sequencer_cmd_issuer (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [9:0]                 fid,
    input  logic [31:0]                op0,
    input  logic [31:0]                op1,
    output logic                       done,
    output logic [31:0]                rsp_word,
    cfu_dot_sequencer_if.master        cfu
);

    logic        r_cmd_valid;
    logic        r_rsp_ready;
    logic [9:0]  r_fid;
    logic [31:0] r_op0;
    logic [31:0] r_op1;

    // Payload is latched at start and left untouched until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_fid       <= '0;
            r_op0       <= '0;
            r_op1       <= '0;
        end else begin
            if (start && !r_cmd_valid && !r_rsp_ready) begin
                r_cmd_valid <= 1'b1;
                r_fid       <= fid;
                r_op0       <= op0;
                r_op1       <= op1;
            end
            if (r_cmd_valid && cfu.cmd_ready) begin
                r_cmd_valid <= 1'b0;
                r_rsp_ready <= 1'b1;
            end
            if (r_rsp_ready && cfu.rsp_valid) begin
                r_rsp_ready <= 1'b0;
            end
        end
    end

    assign cfu.cmd_valid               = r_cmd_valid;
    assign cfu.cmd_payload_function_id = r_fid;
    assign cfu.cmd_payload_inputs_0    = r_op0;
    assign cfu.cmd_payload_inputs_1    = r_op1;
    assign cfu.rsp_ready               = r_rsp_ready;
    assign done                        = r_rsp_ready && cfu.rsp_valid;
    assign rsp_word                    = cfu.rsp_payload_outputs_0;

endmodule

`default_nettype wire

// File: rtl/cfu_dot_sequencer.sv
// ============================================================================
// Module : cfu_dot_sequencer
// Brief  : Sequences one clustered-weight dot-product job onto the CFU port
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cfu_dot_sequencer
    import cfu_dot_sequencer_pkg::*;
#(
    parameter int GROUP_W    = 8,
    parameter int CHECK_TAGS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [1:0]           job_cb_mode,
    input  logic [127:0]         job_codebook,
    input  logic [GROUP_W-1:0]   job_groups,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [63:0]          w_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [63:0]          a_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic                 err_tag,
    output logic                 err_mode,
    cfu_dot_sequencer_if.master  cfu
);

    seq_state_e          r_state, w_state_n;
    cb_mode_e            r_mode;
    logic [127:0]        r_cb;
    logic [GROUP_W-1:0]  r_grp_cnt;
    logic [1:0]          r_mac_cnt;
    logic [31:0]         r_op0, r_op1;
    logic [31:0]         r_res_data;
    logic                r_err_tag, r_err_mode;
    logic                r_issued;

    logic                w_is_cmd, w_start, w_done, w_tag_chk, w_mac_last, w_no_groups;
    logic [9:0]          w_cmd_fid;
    logic [31:0]         w_cmd_op0, w_cmd_op1, w_exp_tag, w_rsp_word;

    cfu_dot_sequencer_cmd_issuer u_issuer (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .fid      (w_cmd_fid),
        .op0      (w_cmd_op0),
        .op1      (w_cmd_op1),
        .done     (w_done),
        .rsp_word (w_rsp_word),
        .cfu      (cfu)
    );

    // Each command state fires its command exactly once, on its first cycle.
    assign w_start     = w_is_cmd && !r_issued;
    assign w_mac_last  = (r_mode == CB_MODE_16) ? (r_mac_cnt == 2'd1) : (r_mac_cnt == 2'd3);
    assign w_no_groups = (r_grp_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_issued   <= 1'b0;
            r_mode     <= CB_MODE_2;
            r_cb       <= '0;
            r_grp_cnt  <= '0;
            r_mac_cnt  <= '0;
            r_op0      <= '0;
            r_op1      <= '0;
            r_res_data <= '0;
            r_err_tag  <= 1'b0;
            r_err_mode <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_issued <= (w_state_n != r_state) ? 1'b0 : (r_issued | w_start);
            case (r_state)
                S_IDLE: if (job_valid) begin
                    r_mode     <= cb_mode_e'(job_cb_mode);
                    r_cb       <= job_codebook;
                    r_grp_cnt  <= job_groups;
                    r_mac_cnt  <= '0;
                    r_res_data <= '0;
                    r_err_tag  <= 1'b0;
                    r_err_mode <= (job_cb_mode == CB_MODE_BAD);
                end
                S_WFETCH: if (w_valid) begin
                    r_op0 <= w_data[31:0];
                    r_op1 <= w_data[63:32];
                end
                S_AFETCH: if (a_valid) begin
                    r_op0 <= a_data[31:0];
                    r_op1 <= a_data[63:32];
                end
                S_MAC: if (w_done) begin
                    if (w_mac_last) begin
                        r_mac_cnt <= '0;
                        r_grp_cnt <= r_grp_cnt - GROUP_W'(1);
                    end else begin
                        r_mac_cnt <= r_mac_cnt + 2'd1;
                    end
                end
                S_READ: if (w_done) r_res_data <= w_rsp_word;
                default: ;
            endcase
            if (w_done && w_tag_chk && (w_rsp_word != w_exp_tag)) begin
                r_err_tag <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_is_cmd  = 1'b0;
        w_cmd_fid = cfu_fid(c_f7_rst);
        w_cmd_op0 = '0;
        w_cmd_op1 = '0;
        w_exp_tag = '0;
        w_tag_chk = 1'b0;
        job_ready = 1'b0;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) w_state_n = (job_cb_mode == CB_MODE_BAD) ? S_OUT : S_RST;
            end
            S_RST: begin
                w_is_cmd  = 1'b1;
                w_tag_chk = (CHECK_TAGS != 0);
                w_exp_tag = c_tag_rst;
                if (w_done) w_state_n = S_CB;
            end
            S_CB: begin
                w_is_cmd  = 1'b1;
                w_tag_chk = (CHECK_TAGS != 0);
                case (r_mode)
                    CB_MODE_2: begin
                        w_cmd_fid = cfu_fid(c_f7_cb2);
                        w_cmd_op0 = {16'b0, r_cb[15:0]};
                        w_exp_tag = c_tag_cb2;
                    end
                    CB_MODE_4: begin
                        w_cmd_fid = cfu_fid(c_f7_cb4);
                        w_cmd_op0 = r_cb[31:0];
                        w_exp_tag = c_tag_cb4;
                    end
                    default: begin
                        w_cmd_fid = cfu_fid(c_f7_cb16);
                        w_cmd_op0 = r_cb[31:0];
                        w_cmd_op1 = r_cb[63:32];
                        w_exp_tag = c_tag_cb16a;
                    end
                endcase
                if (w_done) begin
                    if (r_mode == CB_MODE_16) w_state_n = S_CB16B;
                    else                      w_state_n = w_no_groups ? S_READ : S_WFETCH;
                end
            end
            S_CB16B: begin
                w_is_cmd  = 1'b1;
                w_tag_chk = (CHECK_TAGS != 0);
                w_cmd_fid = cfu_fid(c_f7_cb16);
                w_cmd_op0 = r_cb[95:64];
                w_cmd_op1 = r_cb[127:96];
                w_exp_tag = c_tag_cb16b;
                if (w_done) w_state_n = w_no_groups ? S_READ : S_WFETCH;
            end
            S_WFETCH: begin
                w_ready = 1'b1;
                if (w_valid) w_state_n = S_PUSH;
            end
            S_PUSH: begin
                w_is_cmd  = 1'b1;
                w_tag_chk = (CHECK_TAGS != 0);
                w_cmd_fid = cfu_fid(c_f7_push);
                w_cmd_op0 = r_op0;
                w_cmd_op1 = r_op1;
                w_exp_tag = c_tag_push;
                if (w_done) w_state_n = S_AFETCH;
            end
            S_AFETCH: begin
                a_ready = 1'b1;
                if (a_valid) w_state_n = S_MAC;
            end
            S_MAC: begin
                w_is_cmd  = 1'b1;
                w_tag_chk = (CHECK_TAGS != 0);
                w_cmd_fid = cfu_fid(c_f7_mac);
                w_cmd_op0 = r_op0;
                w_cmd_op1 = r_op1;
                w_exp_tag = c_tag_mac;
                if (w_done) begin
                    if (!w_mac_last)                     w_state_n = S_AFETCH;
                    else if (r_grp_cnt == GROUP_W'(1))   w_state_n = S_READ;
                    else                                 w_state_n = S_WFETCH;
                end
            end
            S_READ: begin
                w_is_cmd  = 1'b1;
                w_cmd_fid = cfu_fid(c_f7_read);
                if (w_done) w_state_n = S_OUT;
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign res_data = r_res_data;
    assign err_tag  = r_err_tag;
    assign err_mode = r_err_mode;

endmodule

`default_nettype wire

// File: tb/tb_cfu_dot_sequencer.sv
// ============================================================================
// Module : tb_cfu_dot_sequencer
// Brief  : Directed bench with a behavioural clustered-weight CFU on the cmd/rsp bus
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cfu_dot_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         job_valid, job_ready;
    logic [1:0]   job_cb_mode;
    logic [127:0] job_codebook;
    logic [7:0]   job_groups;
    logic         w_valid, w_ready, a_valid, a_ready;
    logic [63:0]  w_data, a_data;
    logic         res_valid, res_ready;
    logic [31:0]  res_data;
    logic         err_tag, err_mode;

    cfu_dot_sequencer_if cfu_bus ();

    cfu_dot_sequencer #(.GROUP_W(8), .CHECK_TAGS(1)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_cb_mode(job_cb_mode),
        .job_codebook(job_codebook), .job_groups(job_groups),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_tag(err_tag), .err_mode(err_mode), .cfu(cfu_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural CFU ----------------
    int          cmd_delay = 0, rsp_delay = 0;
    bit          corrupt_cb16a = 1'b0;
    int          stable_err = 0, proto_err = 0, n_mac = 0, excl_err = 0;
    int          m_st = 0, m_cnt = 0, m_acc = 0, m_mode = 0, m_beat = 0;
    bit          m_seen = 1'b0, m_half = 1'b0;
    logic [9:0]  capf;
    logic [31:0] cap0, cap1, m_rsp;
    logic [63:0] m_w;
    logic signed [7:0] m_cb [16];
    logic [9:0]  fid_log [$];
    logic [31:0] op0_log [$];

    task automatic execute(input logic [9:0] f, input logic [31:0] i0, i1, output logic [31:0] r);
        logic [63:0] ad;
        logic signed [7:0] a8;
        int idx, code;
        ad = {i1, i0};
        r  = 32'hFFFF_FFFF;
        case (f)
            10'h240: begin m_acc = 0; r = 32'h0; end
            10'h100: begin m_cb[0] = i0[7:0]; m_cb[1] = i0[15:8]; m_mode = 0; r = 32'hAABB_2202; end
            10'h140: begin
                for (int k = 0; k < 4; k++) m_cb[k] = i0[8*k +: 8];
                m_mode = 1; r = 32'hAABB_4404;
            end
            10'h1C0: begin
                m_mode = 2;
                if (!m_half) begin
                    for (int k = 0; k < 4; k++) begin m_cb[k] = i0[8*k +: 8]; m_cb[k+4] = i1[8*k +: 8]; end
                    m_half = 1'b1;
                    r = corrupt_cb16a ? 32'h0 : 32'hAABB_16A0;
                end else begin
                    for (int k = 0; k < 4; k++) begin m_cb[k+8] = i0[8*k +: 8]; m_cb[k+12] = i1[8*k +: 8]; end
                    m_half = 1'b0;
                    r = 32'hAABB_16B1;
                end
            end
            10'h080: begin m_w = {i1, i0}; m_beat = 0; r = 32'hDEAD_0000; end
            10'h200: begin
                for (int k = 0; k < 8; k++) begin
                    idx = m_beat * 8 + k;
                    if (m_mode == 2)      code = int'(m_w[4*idx +: 4]);
                    else if (m_mode == 1) code = int'(m_w[2*idx +: 2]);
                    else                  code = int'(m_w[2*idx]);
                    a8 = ad[8*k +: 8];
                    m_acc += (int'(a8) + 128) * int'(m_cb[code]);
                end
                m_beat++;
                n_mac++;
                r = 32'hABCD_0001;
            end
            10'h280: r = m_acc;
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (reset) begin
            m_st = 0; m_seen = 1'b0; m_half = 1'b0;
            cfu_bus.cmd_ready = 1'b0;
            cfu_bus.rsp_valid = 1'b0;
            cfu_bus.rsp_payload_outputs_0 = 32'h0;
        end else begin
            if (m_st == 4 && m_seen) begin
                cfu_bus.rsp_valid = 1'b0; m_seen = 1'b0; m_st = 0;
            end
            case (m_st)
                0: if (cfu_bus.cmd_valid) begin
                    capf = cfu_bus.cmd_payload_function_id;
                    cap0 = cfu_bus.cmd_payload_inputs_0;
                    cap1 = cfu_bus.cmd_payload_inputs_1;
                    m_cnt = 0;
                    if (cmd_delay == 0) begin cfu_bus.cmd_ready = 1'b1; m_st = 2; end
                    else m_st = 1;
                end
                1: begin
                    if (!cfu_bus.cmd_valid || cfu_bus.cmd_payload_function_id != capf ||
                        cfu_bus.cmd_payload_inputs_0 != cap0 || cfu_bus.cmd_payload_inputs_1 != cap1)
                        stable_err++;
                    m_cnt++;
                    if (m_cnt >= cmd_delay) begin cfu_bus.cmd_ready = 1'b1; m_st = 2; end
                end
                2: begin
                    cfu_bus.cmd_ready = 1'b0;
                    fid_log.push_back(capf);
                    op0_log.push_back(cap0);
                    execute(capf, cap0, cap1, m_rsp);
                    m_cnt = 0;
                    if (rsp_delay == 0) begin
                        cfu_bus.rsp_valid = 1'b1; cfu_bus.rsp_payload_outputs_0 = m_rsp;
                        m_seen = cfu_bus.rsp_ready; m_st = 4;
                    end else m_st = 3;
                end
                3: begin
                    if (cfu_bus.cmd_valid) proto_err++;
                    m_cnt++;
                    if (m_cnt >= rsp_delay) begin
                        cfu_bus.rsp_valid = 1'b1; cfu_bus.rsp_payload_outputs_0 = m_rsp;
                        m_seen = cfu_bus.rsp_ready; m_st = 4;
                    end
                end
                4: begin
                    if (cfu_bus.cmd_valid) proto_err++;
                    if (cfu_bus.rsp_ready) m_seen = 1'b1;
                end
                default: m_st = 0;
            endcase
        end
    end

    // ---------------- stream sources ----------------
    bit          stream_en = 1'b0, stall_en = 1'b0, stall_tick = 1'b0;
    logic [63:0] w_word = '0, a_word = '0;

    always @(negedge clk) begin
        stall_tick = ~stall_tick;
        w_valid = stream_en && (!stall_en || stall_tick);
        a_valid = stream_en && (!stall_en || !stall_tick);
        w_data  = w_word;
        a_data  = a_word;
        if (w_ready && a_ready) excl_err++;
    end

    task automatic start_job(input logic [1:0] mode, input logic [127:0] cb, input logic [7:0] grp,
                             output bit tmo);
        int n;
        tmo = 1'b0;
        @(negedge clk);
        job_cb_mode = mode; job_codebook = cb; job_groups = grp; job_valid = 1'b1;
        n = 0;
        while (!job_ready && n < 200) begin @(negedge clk); n++; end
        if (!job_ready) tmo = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] mode, input logic [127:0] cb, input logic [7:0] grp,
                           input logic [63:0] wd, ad, input int rdel,
                           output logic [31:0] res, output bit tmo, output bit drop);
        int n;
        res = 32'hDEAD_BEEF; drop = 1'b0;
        w_word = wd; a_word = ad; stream_en = 1'b1;
        start_job(mode, cb, grp, tmo);
        if (!tmo) begin
            n = 0;
            while (!res_valid && n < 5000) begin @(negedge clk); n++; end
            if (!res_valid) tmo = 1'b1;
        end
        if (!tmo) begin
            repeat (rdel) begin @(negedge clk); if (!res_valid) drop = 1'b1; end
            res = res_data;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        stream_en = 1'b0;
    endtask

    localparam logic [127:0] CB_M0 = 128'h05FD;
    localparam logic [127:0] CB_M2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    // ---------------- tests ----------------
    task automatic test_reset();
        total++;
        if (job_ready !== 1'b1) begin bad++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
        total++;
        if ({cfu_bus.cmd_valid, cfu_bus.rsp_ready, res_valid, w_ready, a_ready, err_tag, err_mode} !== 7'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000000",
                {cfu_bus.cmd_valid, cfu_bus.rsp_ready, res_valid, w_ready, a_ready, err_tag, err_mode});
        end
        total++;
        if ({res_data, cfu_bus.cmd_payload_function_id, cfu_bus.cmd_payload_inputs_0, cfu_bus.cmd_payload_inputs_1} !== '0) begin
            bad++; $display("FAIL reset_payload: got res=%h fid=%h in0=%h want zeros",
                res_data, cfu_bus.cmd_payload_function_id, cfu_bus.cmd_payload_inputs_0);
        end
    endtask

    task automatic test_mode0();
        logic [31:0] res; bit tmo, drop; int base;
        base = fid_log.size();
        run_job(2'd0, CB_M0, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, res, tmo, drop);
        total++; if (tmo) begin bad++; $display("FAIL m0_timeout: got 1 want 0"); end
        total++; if (res !== 32'd20480) begin bad++; $display("FAIL m0_result: got %0d want 20480", res); end
        total++; if ({err_tag, err_mode} !== 2'b00) begin bad++; $display("FAIL m0_err: got %b want 00", {err_tag, err_mode}); end
        total++; if (fid_log.size() - base != 8) begin bad++; $display("FAIL m0_cmd_count: got %0d want 8", fid_log.size() - base); end
        if (fid_log.size() - base >= 2) begin
            total++;
            if (fid_log[base+1] !== 10'h100 || op0_log[base+1] !== 32'h0000_05FD) begin
                bad++; $display("FAIL m0_setcb2: got fid=%h op0=%h want 100/000005fd", fid_log[base+1], op0_log[base+1]);
            end
        end
    endtask

    task automatic test_mode2();
        logic [31:0] res; bit tmo, drop; int base;
        base = fid_log.size();
        run_job(2'd2, CB_M2, 8'd1, 64'h1111_1111_1111_1111, 64'h0101_0101_0101_0101, 0, res, tmo, drop);
        total++; if (tmo) begin bad++; $display("FAIL m2_timeout: got 1 want 0"); end
        total++; if (res !== 32'd2064) begin bad++; $display("FAIL m2_result: got %0d want 2064", res); end
        total++; if (fid_log.size() - base != 7) begin bad++; $display("FAIL m2_cmd_count: got %0d want 7", fid_log.size() - base); end
        if (fid_log.size() - base >= 3) begin
            total++;
            if (fid_log[base+1] !== 10'h1C0 || fid_log[base+2] !== 10'h1C0 ||
                op0_log[base+1] !== 32'h0302_0100 || op0_log[base+2] !== 32'h0B0A_0908) begin
                bad++; $display("FAIL m2_setcb16: got %h/%h op0 %h/%h want 1c0/1c0 03020100/0b0a0908",
                    fid_log[base+1], fid_log[base+2], op0_log[base+1], op0_log[base+2]);
            end
        end
        total++; if (err_tag !== 1'b0) begin bad++; $display("FAIL m2_err_tag: got %b want 0", err_tag); end
    endtask

    task automatic test_multi_group();
        logic [31:0] res; bit tmo, drop; int base;
        base = fid_log.size();
        run_job(2'd1, 128'h0403_0201, 8'd2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0202_0202_0202_0202, 0, res, tmo, drop);
        total++; if (res !== 32'd24960 || tmo) begin bad++; $display("FAIL grp2_result: got %0d want 24960", res); end
        total++; if (fid_log.size() - base != 13) begin bad++; $display("FAIL grp2_cmd_count: got %0d want 13", fid_log.size() - base); end
    endtask

    task automatic test_zero_groups();
        logic [31:0] res; bit tmo, drop; int base;
        base = fid_log.size();
        run_job(2'd1, 128'h7F7F_7F7F, 8'd0, 64'h0, 64'h0, 0, res, tmo, drop);
        total++; if (res !== 32'd0 || tmo) begin bad++; $display("FAIL zero_grp_result: got %0d want 0", res); end
        total++;
        if (fid_log.size() - base != 3) begin
            bad++; $display("FAIL zero_grp_count: got %0d want 3", fid_log.size() - base);
        end else if (fid_log[base] !== 10'h240 || fid_log[base+1] !== 10'h140 || fid_log[base+2] !== 10'h280) begin
            bad++; $display("FAIL zero_grp_seq: got %h %h %h want 240 140 280", fid_log[base], fid_log[base+1], fid_log[base+2]);
        end
    endtask

    task automatic test_bad_tag();
        logic [31:0] res; bit tmo, drop;
        corrupt_cb16a = 1'b1;
        run_job(2'd2, CB_M2, 8'd1, 64'h1111_1111_1111_1111, 64'h0101_0101_0101_0101, 0, res, tmo, drop);
        corrupt_cb16a = 1'b0;
        total++; if (err_tag !== 1'b1) begin bad++; $display("FAIL tag_set: got %b want 1", err_tag); end
        total++; if (res !== 32'd2064) begin bad++; $display("FAIL tag_result: got %0d want 2064", res); end
        run_job(2'd0, CB_M0, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, res, tmo, drop);
        total++; if (err_tag !== 1'b0) begin bad++; $display("FAIL tag_clear: got %b want 0", err_tag); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] res; bit tmo, drop; int base, s0, p0;
        base = fid_log.size(); s0 = stable_err; p0 = proto_err;
        cmd_delay = 5; rsp_delay = 3; stall_en = 1'b1;
        run_job(2'd0, CB_M0, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3, res, tmo, drop);
        cmd_delay = 0; rsp_delay = 0; stall_en = 1'b0;
        total++; if (res !== 32'd20480 || tmo) begin bad++; $display("FAIL bp_result: got %0d want 20480", res); end
        total++; if (stable_err != s0) begin bad++; $display("FAIL bp_payload_stable: got %0d changes want 0", stable_err - s0); end
        total++; if (proto_err != p0) begin bad++; $display("FAIL bp_outstanding: got %0d overlaps want 0", proto_err - p0); end
        total++; if (fid_log.size() - base != 8) begin bad++; $display("FAIL bp_cmd_count: got %0d want 8", fid_log.size() - base); end
        total++; if (drop) begin bad++; $display("FAIL bp_res_held: got dropped want held"); end
        total++; if ({job_ready, res_valid} !== 2'b10) begin bad++; $display("FAIL bp_return_idle: got %b want 10", {job_ready, res_valid}); end
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] res; bit tmo, drop; int n, m0, base;
        m0 = n_mac;
        w_word = 64'hFFFF_FFFF_FFFF_FFFF; a_word = 64'h0; stream_en = 1'b1;
        start_job(2'd0, CB_M0, 8'd3, tmo);
        n = 0;
        while (n_mac < m0 + 2 && n < 500) begin @(negedge clk); n++; end
        total++; if (n_mac < m0 + 2) begin bad++; $display("FAIL mid_reach_mac: got %0d macs want 2", n_mac - m0); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        stream_en = 1'b0;
        @(negedge clk);
        total++;
        if ({job_ready, cfu_bus.cmd_valid, cfu_bus.rsp_ready, w_ready, a_ready} !== 5'b10000) begin
            bad++; $display("FAIL mid_idle: got %b want 10000",
                {job_ready, cfu_bus.cmd_valid, cfu_bus.rsp_ready, w_ready, a_ready});
        end
        run_job(2'd0, CB_M0, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, res, tmo, drop);
        total++; if (res !== 32'd20480 || tmo) begin bad++; $display("FAIL mid_second_job: got %0d want 20480", res); end
        base = fid_log.size();
        run_job(2'd3, CB_M0, 8'd1, 64'h0, 64'h0, 0, res, tmo, drop);
        total++; if (err_mode !== 1'b1) begin bad++; $display("FAIL mode3_err: got %b want 1", err_mode); end
        total++; if (res !== 32'd0 || tmo) begin bad++; $display("FAIL mode3_result: got %0d want 0", res); end
        total++; if (fid_log.size() != base) begin bad++; $display("FAIL mode3_no_cmds: got %0d want 0", fid_log.size() - base); end
        run_job(2'd0, CB_M0, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, res, tmo, drop);
        total++; if (err_mode !== 1'b0) begin bad++; $display("FAIL mode3_clear: got %b want 0", err_mode); end
        total++; if (excl_err != 0) begin bad++; $display("FAIL stream_exclusive: got %0d overlaps want 0", excl_err); end
    endtask

    initial begin
        reset = 1'b1; job_valid = 1'b0; job_cb_mode = '0; job_codebook = '0; job_groups = '0;
        res_ready = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_mode0();
        test_mode2();
        test_multi_group();
        test_zero_groups();
        test_bad_tag();
        test_back_pressure();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
